// File: rtl/vx_cache_pkg.sv
// Shared cache types: sweep FSM state encoding and metadata write-port
// priority selection used by the metadata arbiter.
package vx_cache_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SCAN  = 3'd1,
    ST_DRAIN = 3'd2,
    ST_CLEAR = 3'd3,
    ST_DONE  = 3'd4
  } sweep_state_t;

  typedef enum logic [1:0] {
    WR_NONE  = 2'd0,
    WR_FILL  = 2'd1,
    WR_CORE  = 2'd2,
    WR_CLEAR = 2'd3
  } wr_sel_t;

  // Fill beats core, core beats the sweep clear.
  function automatic wr_sel_t wr_select(input logic fill, input logic core, input logic clr);
    wr_sel_t sel;
    sel = WR_NONE;
    if (fill) begin
      sel = WR_FILL;
    end else if (core) begin
      sel = WR_CORE;
    end else if (clr) begin
      sel = WR_CLEAR;
    end
    return sel;
  endfunction

endpackage

// File: rtl/vx_sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over increment).
module vx_sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  // Count up, sticking at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && (count != {WIDTH{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/vx_metadata_arb.sv
// Metadata RAM arbiter: shares one write and one read port between line
// fills, core accesses and a background sweep that counts unused lines.
// Optional macro METADATA_SWEEP_CLEAR_EN makes the sweep clear every used
// bit it finds (CLEAR state); without it the sweep is read-only.
module vx_metadata_arb
  import vx_cache_pkg::*;
#(
  parameter int LINES     = 64,
  parameter int CNT_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     fill_valid,
  input  logic [$clog2(LINES)-1:0] fill_addr,
  input  logic                     core_valid,
  input  logic                     core_rw,
  input  logic                     core_prefetch,
  input  logic [$clog2(LINES)-1:0] core_addr,
  output logic                     core_ready,
  output logic                     core_used,
  input  logic                     sweep_start,
  output logic                     sweep_busy,
  output logic                     sweep_done,
  output logic [CNT_WIDTH-1:0]     sweep_unused,
  output logic                     mem_wren,
  output logic [$clog2(LINES)-1:0] mem_waddr,
  output logic                     mem_wdata,
  output logic [$clog2(LINES)-1:0] mem_raddr,
  input  logic                     mem_rdata
);

  localparam int AW = $clog2(LINES);
  localparam logic [AW-1:0] LAST = AW'(LINES - 1);

  sweep_state_t state, next_state;
  logic [AW-1:0] index;
  logic          sweep_pend;
  logic          core_pend;
  logic          core_acc;
  logic          core_wr;
  logic          sweep_rd;
  logic          clear_req;
  logic          ret_zero;
  wr_sel_t       wr_sel;

  assign core_ready = !fill_valid;
  assign core_acc   = core_valid && core_ready;
  assign core_wr    = core_acc && core_rw && !core_prefetch;
  assign ret_zero   = sweep_pend && !mem_rdata;
  assign sweep_busy = (state == ST_SCAN) || (state == ST_DRAIN) || (state == ST_CLEAR);
  assign sweep_done = (state == ST_DONE);
  assign core_used  = core_pend && mem_rdata;
  assign mem_raddr  = core_acc ? core_addr : index;

`ifdef METADATA_SWEEP_CLEAR_EN
  logic [AW-1:0] pend_addr;
  logic          ret_one;
  logic          clear_done;

  assign ret_one    = sweep_pend && mem_rdata;
  assign clear_req  = (state == ST_CLEAR);
  assign clear_done = clear_req && (wr_sel == WR_CLEAR);
  // One sweep read in flight at a time so a used line can be cleared before moving on.
  assign sweep_rd   = (state == ST_SCAN) && !core_acc && !sweep_pend;

  // Remember which line the in-flight sweep read targets; it is the line to clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_addr <= '0;
    end else if (sweep_rd) begin
      pend_addr <= index;
    end
  end
`else
  assign clear_req  = 1'b0;
  assign sweep_rd   = (state == ST_SCAN) && !core_acc;
`endif

  assign wr_sel = wr_select(fill_valid, core_wr, clear_req);

  // Drive the single write port from the highest-priority requester.
  always_comb begin
    mem_wren  = 1'b0;
    mem_waddr = fill_addr;
    mem_wdata = 1'b0;
    case (wr_sel)
      WR_FILL: begin
        mem_wren  = 1'b1;
        mem_waddr = fill_addr;
        mem_wdata = 1'b0;
      end
      WR_CORE: begin
        mem_wren  = 1'b1;
        mem_waddr = core_addr;
        mem_wdata = 1'b1;
      end
`ifdef METADATA_SWEEP_CLEAR_EN
      WR_CLEAR: begin
        mem_wren  = 1'b1;
        mem_waddr = pend_addr;
        mem_wdata = 1'b0;
      end
`endif
      default: begin
        mem_wren  = 1'b0;
      end
    endcase
  end

  // State register, sweep index and read-in-flight flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      index      <= '0;
      sweep_pend <= 1'b0;
      core_pend  <= 1'b0;
    end else begin
      state      <= next_state;
      sweep_pend <= sweep_rd;
      core_pend  <= core_acc;
      if ((state == ST_IDLE) && sweep_start) begin
        index <= '0;
      end else if (sweep_rd) begin
        index <= index + 1'b1;
      end
    end
  end

  // Sweep sequencing: scan every line, wait for the final read, pulse done.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (sweep_start) next_state = ST_SCAN;
      end
      ST_SCAN: begin
`ifdef METADATA_SWEEP_CLEAR_EN
        if (ret_one) next_state = ST_CLEAR;
        else
`endif
        if (sweep_rd && (index == LAST)) next_state = ST_DRAIN;
      end
      ST_DRAIN: begin
`ifdef METADATA_SWEEP_CLEAR_EN
        if (ret_one) next_state = ST_CLEAR;
        else
`endif
        next_state = ST_DONE;
      end
      ST_CLEAR: begin
`ifdef METADATA_SWEEP_CLEAR_EN
        if (clear_done) next_state = (pend_addr == LAST) ? ST_DONE : ST_SCAN;
`else
        next_state = ST_IDLE;
`endif
      end
      ST_DONE: begin
        next_state = ST_IDLE;
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

  vx_sat_counter #(
    .WIDTH(CNT_WIDTH)
  ) u_unused_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   ((state == ST_IDLE) && sweep_start),
    .inc     (ret_zero),
    .count   (sweep_unused)
  );

endmodule

// File: tb/tb_vx_metadata_arb.sv
// Self-checking bench for vx_metadata_arb (LINES=8) with a behavioural
// one-bit metadata RAM and scoreboard queues for core_used and sweep_unused.
// Expectations adapt to METADATA_SWEEP_CLEAR_EN when it is defined.
module tb_vx_metadata_arb;

  logic        clk;
  logic        reset_n;
  logic        fill_valid;
  logic [2:0]  fill_addr;
  logic        core_valid;
  logic        core_rw;
  logic        core_prefetch;
  logic [2:0]  core_addr;
  logic        core_ready;
  logic        core_used;
  logic        sweep_start;
  logic        sweep_busy;
  logic        sweep_done;
  logic [15:0] sweep_unused;
  logic        mem_wren;
  logic [2:0]  mem_waddr;
  logic        mem_wdata;
  logic [2:0]  mem_raddr;
  logic        mem_rdata;

  logic [7:0]  ram;
  logic [7:0]  load_img;
  logic        load_req;

  logic        core_q[$];
  logic [15:0] unused_q[$];

  int checks;
  int errors;

  vx_metadata_arb #(
    .LINES(8),
    .CNT_WIDTH(16)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .fill_valid    (fill_valid),
    .fill_addr     (fill_addr),
    .core_valid    (core_valid),
    .core_rw       (core_rw),
    .core_prefetch (core_prefetch),
    .core_addr     (core_addr),
    .core_ready    (core_ready),
    .core_used     (core_used),
    .sweep_start   (sweep_start),
    .sweep_busy    (sweep_busy),
    .sweep_done    (sweep_done),
    .sweep_unused  (sweep_unused),
    .mem_wren      (mem_wren),
    .mem_waddr     (mem_waddr),
    .mem_wdata     (mem_wdata),
    .mem_raddr     (mem_raddr),
    .mem_rdata     (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Metadata RAM model: synchronous write, registered read, bulk preload port.
  always @(posedge clk) begin
    if (load_req) ram <= load_img;
    else if (mem_wren) ram[mem_waddr] <= mem_wdata;
    mem_rdata <= ram[mem_raddr];
  end

  task automatic load(input logic [7:0] img);
    load_img = img;
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
    @(negedge clk);
  endtask

  // Start a sweep with no traffic, wait for done, compare against the scoreboard.
  task automatic run_sweep(input logic [15:0] exp_unused, input int exp_cycles, output bit wr_seen);
    int cycles;
    logic [15:0] exp;
    unused_q.push_back(exp_unused);
    wr_seen = 1'b0;
    sweep_start = 1'b1;
    @(negedge clk);
    sweep_start = 1'b0;
    cycles = 1;
    checks++;
    if (sweep_busy !== 1'b1 || mem_raddr !== 3'd0) begin
      errors++;
      $display("[TB] FAIL sweep_first_read: busy=%0b raddr=%0d expected busy=1 raddr=0", sweep_busy, mem_raddr);
    end
    while (!sweep_done && cycles < 200) begin
      if (mem_wren) wr_seen = 1'b1;
      @(negedge clk);
      cycles++;
    end
    exp = unused_q.pop_front();
    checks++;
    if (sweep_done !== 1'b1) begin
      errors++;
      $display("[TB] FAIL sweep_timeout: no sweep_done after %0d cycles", cycles);
    end else begin
      checks++;
      if (sweep_unused !== exp) begin
        errors++;
        $display("[TB] FAIL sweep_unused: got %0d expected %0d", sweep_unused, exp);
      end
      if (exp_cycles != 0) begin
        checks++;
        if (cycles != exp_cycles) begin
          errors++;
          $display("[TB] FAIL sweep_latency: got %0d cycles expected %0d", cycles, exp_cycles);
        end
      end
    end
    @(negedge clk);
    checks++;
    if (sweep_done !== 1'b0 || sweep_busy !== 1'b0 || sweep_unused !== exp) begin
      errors++;
      $display("[TB] FAIL sweep_after: done=%0b busy=%0b unused=%0d expected 0 0 %0d",
               sweep_done, sweep_busy, sweep_unused, exp);
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (sweep_busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %0b expected 0", sweep_busy); end
    checks++;
    if (sweep_done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %0b expected 0", sweep_done); end
    checks++;
    if (sweep_unused !== 16'd0) begin errors++; $display("[TB] FAIL reset_unused: got %0d expected 0", sweep_unused); end
    checks++;
    if (core_used !== 1'b0) begin errors++; $display("[TB] FAIL reset_core_used: got %0b expected 0", core_used); end
    checks++;
    if (mem_wren !== 1'b0) begin errors++; $display("[TB] FAIL reset_wren: got %0b expected 0", mem_wren); end
    checks++;
    if (core_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready: got %0b expected 1", core_ready); end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_idle_sweep;
    bit wr_seen;
    load(8'h00);
`ifdef METADATA_SWEEP_CLEAR_EN
    run_sweep(16'd8, 17, wr_seen);
`else
    run_sweep(16'd8, 10, wr_seen);
`endif
    checks++;
    if (wr_seen !== 1'b0) begin errors++; $display("[TB] FAIL idle_sweep_wren: got %0b expected 0", wr_seen); end
  endtask

  task automatic test_fill_core_collision;
    logic exp;
    load(8'h00);
    fill_valid = 1'b1; fill_addr = 3'd3;
    core_valid = 1'b1; core_rw = 1'b1; core_prefetch = 1'b0; core_addr = 3'd5;
    #1;
    checks++;
    if (mem_wren !== 1'b1 || mem_waddr !== 3'd3 || mem_wdata !== 1'b0) begin
      errors++;
      $display("[TB] FAIL collide_fill_write: wren=%0b waddr=%0d wdata=%0b expected 1 3 0", mem_wren, mem_waddr, mem_wdata);
    end
    checks++;
    if (core_ready !== 1'b0) begin errors++; $display("[TB] FAIL collide_ready: got %0b expected 0", core_ready); end
    @(negedge clk);
    fill_valid = 1'b0;
    #1;
    checks++;
    if (mem_wren !== 1'b1 || mem_waddr !== 3'd5 || mem_wdata !== 1'b1) begin
      errors++;
      $display("[TB] FAIL collide_core_write: wren=%0b waddr=%0d wdata=%0b expected 1 5 1", mem_wren, mem_waddr, mem_wdata);
    end
    checks++;
    if (core_ready !== 1'b1) begin errors++; $display("[TB] FAIL collide_ready_after: got %0b expected 1", core_ready); end
    core_q.push_back(1'b0);
    @(negedge clk);
    core_valid = 1'b0;
    exp = core_q.pop_front();
    checks++;
    if (core_used !== exp) begin errors++; $display("[TB] FAIL collide_core_used: got %0b expected %0b", core_used, exp); end
    checks++;
    if (ram !== 8'h20) begin errors++; $display("[TB] FAIL collide_ram: got %02h expected 20", ram); end
  endtask

  task automatic test_prefetch;
    logic exp;
    core_valid = 1'b1; core_rw = 1'b1; core_prefetch = 1'b1; core_addr = 3'd5;
    #1;
    checks++;
    if (mem_wren !== 1'b0) begin errors++; $display("[TB] FAIL prefetch_wren: got %0b expected 0", mem_wren); end
    core_q.push_back(1'b1);
    @(negedge clk);
    exp = core_q.pop_front();
    checks++;
    if (core_used !== exp) begin errors++; $display("[TB] FAIL prefetch_used: got %0b expected %0b", core_used, exp); end
    core_rw = 1'b0; core_prefetch = 1'b0; core_addr = 3'd3;
    core_q.push_back(1'b0);
    @(negedge clk);
    core_valid = 1'b0;
    exp = core_q.pop_front();
    checks++;
    if (core_used !== exp) begin errors++; $display("[TB] FAIL read_used: got %0b expected %0b", core_used, exp); end
    checks++;
    if (ram !== 8'h20) begin errors++; $display("[TB] FAIL prefetch_ram: got %02h expected 20", ram); end
  endtask

  task automatic test_sweep_with_core;
    int cyc;
    bit pend;
    logic exp;
    logic [15:0] exp_u;
    load(8'h05);
    unused_q.push_back(16'd6);
    pend = 1'b0;
    sweep_start = 1'b1;
    @(negedge clk);
    sweep_start = 1'b0;
    cyc = 1;
    while (!sweep_done && cyc < 200) begin
      if (pend) begin
        exp = core_q.pop_front();
        checks++;
        if (core_used !== exp) begin errors++; $display("[TB] FAIL sweep_core_used: got %0b expected %0b", core_used, exp); end
      end
      core_valid = cyc[0];
      core_rw = 1'b0; core_prefetch = 1'b0;
      core_addr = 3'(((cyc / 2) % 4) * 2 + 1);
      if (core_valid) core_q.push_back(1'b0);
      pend = core_valid;
      @(negedge clk);
      cyc++;
    end
    core_valid = 1'b0;
    if (pend) begin
      exp = core_q.pop_front();
      checks++;
      if (core_used !== exp) begin errors++; $display("[TB] FAIL sweep_core_used: got %0b expected %0b", core_used, exp); end
    end
    exp_u = unused_q.pop_front();
    checks++;
    if (sweep_done !== 1'b1) begin
      errors++;
      $display("[TB] FAIL sweep_core_timeout: no sweep_done after %0d cycles", cyc);
    end else begin
      checks++;
      if (sweep_unused !== exp_u) begin errors++; $display("[TB] FAIL sweep_core_unused: got %0d expected %0d", sweep_unused, exp_u); end
      checks++;
`ifdef METADATA_SWEEP_CLEAR_EN
      if (cyc < 16 || cyc > 40) begin
`else
      if (cyc < 16 || cyc > 20) begin
`endif
        errors++;
        $display("[TB] FAIL sweep_core_latency: got %0d cycles expected about 18", cyc);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_sweep;
    int n;
    bit done_seen;
    bit wr_seen;
    load(8'h05);
    sweep_start = 1'b1;
    @(negedge clk);
    sweep_start = 1'b0;
    n = 0;
    while (!(mem_raddr == 3'd4 && sweep_busy) && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (mem_raddr !== 3'd4 || sweep_busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL mid_reach_index4: raddr=%0d busy=%0b expected 4 1", mem_raddr, sweep_busy);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if (sweep_busy !== 1'b0 || sweep_done !== 1'b0 || sweep_unused !== 16'd0) begin
      errors++;
      $display("[TB] FAIL mid_reset_state: busy=%0b done=%0b unused=%0d expected 0 0 0", sweep_busy, sweep_done, sweep_unused);
    end
    done_seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (sweep_done) done_seen = 1'b1;
    end
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (sweep_done) done_seen = 1'b1;
    end
    checks++;
    if (done_seen !== 1'b0) begin errors++; $display("[TB] FAIL mid_no_done: got %0b expected 0", done_seen); end
    load(8'h05);
`ifdef METADATA_SWEEP_CLEAR_EN
    run_sweep(16'd6, 0, wr_seen);
`else
    run_sweep(16'd6, 10, wr_seen);
`endif
  endtask

  task automatic test_sweep_clear;
    bit wr_seen;
    load(8'h42);
    run_sweep(16'd6, 0, wr_seen);
    checks++;
`ifdef METADATA_SWEEP_CLEAR_EN
    if (ram !== 8'h00) begin errors++; $display("[TB] FAIL clear_ram: got %02h expected 00", ram); end
    run_sweep(16'd8, 17, wr_seen);
`else
    if (ram !== 8'h42 || wr_seen !== 1'b0) begin
      errors++;
      $display("[TB] FAIL noclear_ram: ram=%02h wren_seen=%0b expected 42 0", ram, wr_seen);
    end
    run_sweep(16'd6, 10, wr_seen);
`endif
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset_n = 1'b0;
    fill_valid = 1'b0; fill_addr = 3'd0;
    core_valid = 1'b0; core_rw = 1'b0; core_prefetch = 1'b0; core_addr = 3'd0;
    sweep_start = 1'b0;
    load_req = 1'b0; load_img = 8'h00;
    test_reset();
    test_idle_sweep();
    test_fill_core_collision();
    test_prefetch();
    test_sweep_with_core();
    test_reset_mid_sweep();
    test_sweep_clear();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vx_metadata_arb.md
VX_METADATA_ARB -- requirements
Module: VX_metadata_arb

Interface
- REQ-001 SHALL have parameter LINES, default 64, meaning metadata entries per bank (power of two, >=2).
- REQ-002 SHALL have parameter CNT_WIDTH, default 16, meaning width of the unused-line counter.
- REQ-003 SHALL have ports: clk in 1, sole clock; reset_n in 1, asynchronous active-low reset.
- REQ-004 SHALL have ports: fill_valid in 1; fill_addr in log2(LINES), fill line index.
- REQ-005 SHALL have ports: core_valid in 1; core_rw in 1; core_prefetch in 1; core_addr in log2(LINES); core_ready out 1.
- REQ-006 SHALL have ports: core_used out 1, used bit of the accepted core access.
- REQ-007 SHALL have ports: sweep_start in 1, pulse; sweep_busy out 1; sweep_done out 1, one-cycle pulse; sweep_unused out CNT_WIDTH, count of lines with used=0.
- REQ-008 SHALL have ports: mem_wren out 1; mem_waddr out log2(LINES); mem_wdata out 1; mem_raddr out log2(LINES); mem_rdata in 1, valid one cycle after mem_raddr.

Function
- REQ-009 Write port priority SHALL be fill > core > sweep-clear; fill writes wdata=0, core writes wdata=1 only when core_rw=1 and core_prefetch=0.
- REQ-010 core_ready SHALL equal !fill_valid; a core access is accepted when core_valid && core_ready.
- REQ-011 Read port priority SHALL be core > sweep; an accepted core access drives mem_raddr=core_addr and core_used equals mem_rdata one cycle later.
- REQ-012 FSM states SHALL be IDLE, SCAN, DRAIN, CLEAR, DONE.
- REQ-013 IDLE->SCAN on sweep_start; index and sweep_unused reset to 0 on entry; sweep_start ignored outside IDLE.
- REQ-014 SCAN SHALL issue sweep read of index on each cycle the read port is not taken by the core, then increment; after issuing index LINES-1 -> DRAIN.
- REQ-015 Each sweep read returning 0 SHALL increment sweep_unused, saturating at 2^CNT_WIDTH-1.
- REQ-016 DRAIN SHALL wait one cycle for the last rdata, then -> DONE; DONE asserts sweep_done one cycle and -> IDLE.
- REQ-017 sweep_busy SHALL be 1 in SCAN, DRAIN, CLEAR; sweep_unused SHALL hold its value until next sweep_start.
- REQ-018 A fill or core write to a line already scanned in the current sweep SHALL NOT alter sweep_unused.
- REQ-019 Simultaneous fill_valid and core_valid SHALL stall core only; sweep progress is unaffected by fill (read port free).

Reset
- REQ-020 On reset_n low, FSM SHALL go to IDLE, index and pending-read flag clear, sweep_unused=0, sweep_done=0, sweep_busy=0, core_used=0, mem_wren=0.
- REQ-021 Reset mid-sweep SHALL abandon the sweep without a sweep_done pulse.
- REQ-022 Reset SHALL NOT initialise the metadata RAM contents.

Configuration
- REQ-023 Macro METADATA_SWEEP_CLEAR_EN: when defined, each sweep read returning 1 SHALL enter CLEAR and write 0 to that line when fill and core are not writing, stalling the scan until written; then return to SCAN (or DRAIN/DONE path if last).
- REQ-024 Without METADATA_SWEEP_CLEAR_EN, CLEAR SHALL be unreachable and the sweep SHALL never drive mem_wren.

Structure
- REQ-025 FSM state enum and priority encoding SHALL live in shared package VX_cache_pkg.
- REQ-026 Counter saturation SHALL be sub-module VX_sat_counter; the RAM remains outside this block.

Verification
- REQ-027 LINES=8, all used=0, sweep_start, no traffic -> sweep_done 10 cycles later, sweep_unused=8.
- REQ-028 fill_valid and core_valid(rw=1) same cycle, addr 3 and 5 -> mem_waddr=3 wdata=0, core_ready=0; next cycle mem_waddr=5 wdata=1.
- REQ-029 Core prefetch write (rw=1, prefetch=1) -> mem_wren=0; core_used returns stored bit next cycle.
- REQ-030 Sweep with core_valid every other cycle, lines 0,2 used=1 -> sweep_unused=6, duration about double idle case.
- REQ-031 reset_n low at index 4 -> sweep_busy=0 immediately, no sweep_done; new sweep_start restarts at 0.
- REQ-032 With METADATA_SWEEP_CLEAR_EN, lines 1,6 used=1 -> both written 0; a second sweep reports sweep_unused=8.
